td4_core: RTL and testbench
===========================

Name: td4_core

Overview:
- Execution core of the TD4-class 4-bit CPU, sitting directly downstream of the 16x8 instruction ROM.
- Drives the ROM address from its program counter and consumes the 8-bit instruction word that comes back.
- Holds registers A and B, the carry flag and the output port latch.
- Executes one instruction per enabled clock. The ROM read is combinational, so the ROM is in the same cycle.

Parameters:
- RESET_PC, 4'h0: PC value loaded on reset.
- IN_SYNC, 2: number of synchroniser flops on in_port. Legal range is 0..3; 0 means in_port is used directly.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- step_en  in  1  execute the current instruction on this edge when 1; hold all state when 0.
- rom_adr  out  4  instruction address, equal to the PC register.
- rom_data  in  8  instruction word. [7:4] is the opcode, [3:0] is Im.
- in_port  in  4  external input, asynchronous to clk.
- out_port  out  4  output port latch.
- carry  out  1  carry flag, for debug/observation.
- reg_a  out  4  register A, for debug.
- reg_b  out  4  register B, for debug.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-instruction):
  - PC <= RESET_PC.
  - A, B, out_port, carry and all synchroniser flops <= 0.
  - rom_adr follows PC immediately.
- Release of reset is synchronous to clk. The first instruction executes on the first rising edge with rst_n=1 and step_en=1.
- Datapath:
  - ALU = src + Im, a 5-bit result. sum = result[3:0], cout = result[4].
  - src is selected by the opcode from: A, B, in_sync or 0.
- Every enabled edge:
  - carry <= cout. Carry is therefore cleared by any instruction that does not overflow, including MOV, JMP, JNC and OUT.
  - PC <= PC+1, modulo 16 (15 wraps to 0), unless a jump is taken.
- Opcodes (src ; destination):
  - 0000 ADD A,Im: src A ; A <= sum.
  - 0101 ADD B,Im: src B ; B <= sum.
  - 0011 MOV A,Im: src 0 ; A <= sum.
  - 0111 MOV B,Im: src 0 ; B <= sum.
  - 0001 MOV A,B: src B ; A <= sum. Im is added, so Im=0 gives a pure move.
  - 0100 MOV B,A: src A ; B <= sum.
  - 0010 IN A: src in_sync ; A <= sum.
  - 0110 IN B: src in_sync ; B <= sum.
  - 1001 OUT B: src B ; out_port <= sum.
  - 1011 OUT Im: src 0 ; out_port <= sum.
  - 1111 JMP Im: src 0 ; PC <= sum.
  - 1110 JNC Im: src 0 ; PC <= sum if the carry flag before the edge is 0, else PC+1.
  - All other opcodes are NOP: src 0, no register write, PC+1, carry <= cout (which is 0).
- JNC tests the registered carry from the previous instruction, never the current cout.
- in_sync:
  - in_port delayed through IN_SYNC flops, clocked every cycle regardless of step_en.
  - A value on in_port becomes visible to IN after IN_SYNC edges.
- step_en=0: PC, A, B, carry and out_port hold. rom_adr is stable.
- rom_data is sampled only on enabled edges. X on rom_data while step_en=0 has no effect.
- The only register with multiple writers is PC. Jump target and increment are mutually exclusive by opcode, so there is no write conflict.

Decomposition:
- td4_pkg holds:
  - Opcode localparams: OP_ADD_A, OP_ADD_B, OP_MOV_A_IM, OP_MOV_B_IM, OP_MOV_A_B, OP_MOV_B_A, OP_IN_A, OP_IN_B, OP_OUT_B, OP_OUT_IM, OP_JMP, OP_JNC.
  - src-select enum: SRC_A, SRC_B, SRC_IN, SRC_ZERO.
  - Destination load-enable bit positions.
- Sub-module td4_alu: combinational 4-bit src+Im, producing sum and cout.
- Decode, registers and synchroniser stay in td4_core.

Test Plan:
- Reset mid-run: with PC=6, A=5, out_port=3, pulse rst_n low between edges -> PC, rom_adr, A, B, out_port and carry read 0 before the next edge.
- Program 0x33, 0x0E, 0xE5 (MOV A,3; ADD A,14; JNC 5) -> A=3; then A=1 with carry=1; JNC not taken so PC=3 and carry=0; a second JNC 5 at PC=3 jumps to PC=5.
- Program 0xBA, 0x77, 0x90 (OUT Im 10; MOV B,7; OUT B) -> out_port=0xA after edge 1, B=7 after edge 2, out_port=0x7 after edge 3.
- IN_SYNC=2, in_port=9 held, instruction 0x28 (IN A,8) executed 2 edges later -> A=1, carry=1. The same instruction executed 1 edge after in_port changed from 0 -> A=8, carry=0.
- Wrap: NOP at PC=15 -> PC=0. JMP 15 (0xFF) at PC=15 -> PC stays 15 indefinitely.
- step_en held low for 5 edges during the ADD sequence with rom_data driven to X -> PC, A, B, carry and out_port unchanged. Execution resumes correctly when step_en returns to 1.

Source files
------------

// File: rtl/td4_pkg.sv
// td4_pkg: shared widths, opcode encodings, ALU source select and
// destination load-enable bit positions for the TD4 execution core.
package td4_pkg;

    localparam int unsigned DW = 4;          // datapath width
    localparam int unsigned IW = 8;          // instruction word width
    localparam int unsigned RW = DW + 1;     // ALU result width (with carry)

    // Opcodes (instruction bits [7:4])
    localparam logic [3:0] OP_ADD_A    = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B    = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    // ALU left-operand select
    typedef enum logic [1:0] {
        SRC_A    = 2'd0,
        SRC_B    = 2'd1,
        SRC_IN   = 2'd2,
        SRC_ZERO = 2'd3
    } src_sel_e;

    // Destination load-enable bit positions
    localparam int unsigned LD_A   = 0;
    localparam int unsigned LD_B   = 1;
    localparam int unsigned LD_OUT = 2;
    localparam int unsigned LD_PC  = 3;
    localparam int unsigned LD_W   = 4;

endpackage

// File: rtl/td4_alu.sv
// td4_alu: combinational 4-bit adder, src + im.
// Ports: src, im (operands); sum_c (low 4 bits); cout_c (carry out).
module td4_alu
    import td4_pkg::*;
(
    input  logic [DW-1:0] src,
    input  logic [DW-1:0] im,
    output logic [DW-1:0] sum_c,
    output logic          cout_c
);

    logic [RW-1:0] res;

    assign res    = RW'(src) + RW'(im);
    assign sum_c  = res[DW-1:0];
    assign cout_c = res[DW];

endmodule

// File: rtl/td4_core.sv
// td4_core: TD4-class 4-bit CPU execution core. Fetches from a combinational
// 16x8 ROM, executes one instruction per enabled clock edge.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   step_en           execute the current instruction on this edge
//   rom_adr [3:0]     instruction address (the PC register)
//   rom_data[7:0]     instruction word: [7:4] opcode, [3:0] immediate
//   in_port [3:0]     asynchronous external input
//   out_port[3:0]     output port latch
//   carry             carry flag
//   reg_a, reg_b      general registers (debug view)
module td4_core
    import td4_pkg::*;
#(
    parameter logic [3:0]  RESET_PC = 4'h0,
    parameter int unsigned IN_SYNC  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step_en,
    output logic [DW-1:0] rom_adr,
    input  logic [IW-1:0] rom_data,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] out_port,
    output logic          carry,
    output logic [DW-1:0] reg_a,
    output logic [DW-1:0] reg_b
);

    logic [DW-1:0] pc_q;
    logic [DW-1:0] in_sync;
    logic [3:0]    opcode;
    logic [DW-1:0] im;
    src_sel_e      src_sel;
    logic [LD_W-1:0] ld;
    logic [DW-1:0] alu_src;
    logic [DW-1:0] sum;
    logic          cout;

    assign rom_adr = pc_q;

    // Input synchroniser chain; free-running, independent of step_en.
    generate
        if (IN_SYNC == 0) begin : g_nosync
            assign in_sync = in_port;
        end else begin : g_sync
            logic [DW-1:0] sync_q [IN_SYNC];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(IN_SYNC); i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= in_port;
                    for (int i = 1; i < int'(IN_SYNC); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign in_sync = sync_q[IN_SYNC-1];
        end
    endgenerate

    // Decode: ALU source and destination load enables.
    always_comb begin
        opcode  = rom_data[7:4];
        im      = rom_data[3:0];
        src_sel = SRC_ZERO;
        ld      = '0;
        case (opcode)
            OP_ADD_A:    begin src_sel = SRC_A;    ld[LD_A]   = 1'b1; end
            OP_ADD_B:    begin src_sel = SRC_B;    ld[LD_B]   = 1'b1; end
            OP_MOV_A_IM: begin src_sel = SRC_ZERO; ld[LD_A]   = 1'b1; end
            OP_MOV_B_IM: begin src_sel = SRC_ZERO; ld[LD_B]   = 1'b1; end
            OP_MOV_A_B:  begin src_sel = SRC_B;    ld[LD_A]   = 1'b1; end
            OP_MOV_B_A:  begin src_sel = SRC_A;    ld[LD_B]   = 1'b1; end
            OP_IN_A:     begin src_sel = SRC_IN;   ld[LD_A]   = 1'b1; end
            OP_IN_B:     begin src_sel = SRC_IN;   ld[LD_B]   = 1'b1; end
            OP_OUT_B:    begin src_sel = SRC_B;    ld[LD_OUT] = 1'b1; end
            OP_OUT_IM:   begin src_sel = SRC_ZERO; ld[LD_OUT] = 1'b1; end
            OP_JMP:      begin src_sel = SRC_ZERO; ld[LD_PC]  = 1'b1; end
            // JNC looks at the registered carry from the previous instruction.
            OP_JNC:      begin src_sel = SRC_ZERO; ld[LD_PC]  = ~carry; end
            default:     begin src_sel = SRC_ZERO; ld = '0; end
        endcase
    end

    // ALU operand mux.
    always_comb begin
        alu_src = '0;
        case (src_sel)
            SRC_A:    alu_src = reg_a;
            SRC_B:    alu_src = reg_b;
            SRC_IN:   alu_src = in_sync;
            SRC_ZERO: alu_src = '0;
            default:  alu_src = '0;
        endcase
    end

    td4_alu u_alu (
        .src    (alu_src),
        .im     (im),
        .sum_c  (sum),
        .cout_c (cout)
    );

    // Architectural state; everything holds when step_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            reg_a    <= '0;
            reg_b    <= '0;
            out_port <= '0;
            carry    <= 1'b0;
        end else if (step_en) begin
            carry <= cout;
            pc_q  <= ld[LD_PC] ? sum : DW'(pc_q + DW'(1));
            if (ld[LD_A])   reg_a    <= sum;
            if (ld[LD_B])   reg_b    <= sum;
            if (ld[LD_OUT]) out_port <= sum;
        end
    end

endmodule

// File: tb/tb_td4_core.sv
// tb_td4_core: directed scenarios plus randomized programs checked against
// an instruction-level reference model of the TD4 core.
module tb_td4_core;

    localparam int IN_SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_en = 1'b0;
    logic [3:0] rom_adr;
    logic [7:0] rom_data;
    logic [3:0] in_port = 4'h0;
    logic [3:0] out_port;
    logic       carry;
    logic [3:0] reg_a;
    logic [3:0] reg_b;

    logic [7:0] rom [16];
    logic       use_rom = 1'b1;
    logic [7:0] rom_drv = 8'h80;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_pc, m_a, m_b, m_out, m_c;
    int hist[$];

    logic [16:0] dut_st;
    assign dut_st   = {rom_adr, reg_a, reg_b, out_port, carry};
    assign rom_data = use_rom ? rom[rom_adr] : rom_drv;

    always #5 clk = ~clk;

    td4_core #(.RESET_PC(4'h0), .IN_SYNC(IN_SYNC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_en  (step_en),
        .rom_adr  (rom_adr),
        .rom_data (rom_data),
        .in_port  (in_port),
        .out_port (out_port),
        .carry    (carry),
        .reg_a    (reg_a),
        .reg_b    (reg_b)
    );

    function automatic logic [16:0] st(int pc, int a, int b, int o, int c);
        return {4'(pc), 4'(a), 4'(b), 4'(o), 1'(c)};
    endfunction

    function automatic logic [16:0] model_st();
        return st(m_pc, m_a, m_b, m_out, m_c);
    endfunction

    // Instruction semantics with plain integer arithmetic.
    task automatic model_exec(input logic [7:0] w, input int insv);
        int op, imm, src, r, sum, cy, next_pc;
        op  = int'(w[7:4]);
        imm = int'(w[3:0]);
        case (op)
            0, 4:      src = m_a;
            1, 5, 9:   src = m_b;
            2, 6:      src = insv;
            default:   src = 0;
        endcase
        r       = src + imm;
        sum     = r % 16;
        cy      = r / 16;
        next_pc = (m_pc + 1) % 16;
        case (op)
            0, 1, 2, 3: m_a = sum;
            4, 5, 6, 7: m_b = sum;
            9, 11:      m_out = sum;
            15:         next_pc = sum;
            14:         if (m_c == 0) next_pc = sum;
            default:    ;
        endcase
        m_c  = cy;
        m_pc = next_pc;
    endtask

    // One clock edge: capture pre-edge inputs, advance model, settle.
    task automatic clk_edge();
        logic [7:0] w;
        int inv, insv;
        logic en;
        w   = use_rom ? rom[m_pc] : rom_drv;
        inv = int'(in_port);
        if (IN_SYNC == 0) insv = inv;
        else if (hist.size() >= IN_SYNC) insv = hist[hist.size() - IN_SYNC];
        else insv = 0;
        en = step_en;
        @(posedge clk);
        hist.push_back(inv);
        if (hist.size() > 8) void'(hist.pop_front());
        if (en) model_exec(w, insv);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0;
        hist.delete();
    endtask

    // Asynchronous reset pulse between edges; leaves rst_n high.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic load_rom(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_st !== st(0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_init: got %h want %h", dut_st, st(0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
        model_reset();
        // Mid-run reset: reach PC=6, A=5, out=3.
        use_rom = 1'b1;
        load_rom(8'h35, 8'hB3, 8'h80, 8'h80);
        step_en = 1'b1;
        for (int i = 0; i < 6; i++) clk_edge();
        n_cmp++;
        if (dut_st !== st(6, 5, 0, 3, 0)) begin
            n_err++;
            $display("FAIL reset_prerun: got %h want %h", dut_st, st(6, 5, 0, 3, 0));
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_st !== st(0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_midrun: got %h want %h", dut_st, st(0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_add_jnc();
        logic [16:0] exp [4];
        exp[0] = st(1, 3, 0, 0, 0);
        exp[1] = st(2, 1, 0, 0, 1);
        exp[2] = st(3, 1, 0, 0, 0);
        exp[3] = st(5, 1, 0, 0, 0);
        use_rom = 1'b1;
        load_rom(8'h33, 8'h0E, 8'hE5, 8'hE5);
        do_reset();
        step_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_edge();
            n_cmp++;
            if (dut_st !== exp[i]) begin
                n_err++;
                $display("FAIL add_jnc e%0d: got %h want %h", i + 1, dut_st, exp[i]);
            end
        end
    endtask

    task automatic test_out();
        logic [16:0] exp [3];
        exp[0] = st(1, 0, 0, 10, 0);
        exp[1] = st(2, 0, 7, 10, 0);
        exp[2] = st(3, 0, 7, 7, 0);
        use_rom = 1'b1;
        load_rom(8'hBA, 8'h77, 8'h90, 8'h80);
        do_reset();
        step_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            n_cmp++;
            if (dut_st !== exp[i]) begin
                n_err++;
                $display("FAIL out e%0d: got %h want %h", i + 1, dut_st, exp[i]);
            end
        end
    endtask

    task automatic test_in_sync();
        use_rom = 1'b0;
        rom_drv = 8'h28;
        // Value held for IN_SYNC edges is visible.
        in_port = 4'h0;
        do_reset();
        step_en = 1'b0;
        in_port = 4'h9;
        clk_edge();
        clk_edge();
        step_en = 1'b1;
        clk_edge();
        n_cmp++;
        if (dut_st !== st(1, 1, 0, 0, 1)) begin
            n_err++;
            $display("FAIL in_2edges: got %h want %h", dut_st, st(1, 1, 0, 0, 1));
        end
        // Only one edge after the change: still sees the old value.
        in_port = 4'h0;
        do_reset();
        step_en = 1'b0;
        clk_edge();
        clk_edge();
        in_port = 4'h9;
        clk_edge();
        step_en = 1'b1;
        clk_edge();
        n_cmp++;
        if (dut_st !== st(1, 8, 0, 0, 0)) begin
            n_err++;
            $display("FAIL in_1edge: got %h want %h", dut_st, st(1, 8, 0, 0, 0));
        end
        in_port = 4'h0;
        use_rom = 1'b1;
    endtask

    task automatic test_wrap();
        use_rom = 1'b1;
        load_rom(8'h80, 8'h80, 8'h80, 8'h80);
        do_reset();
        step_en = 1'b1;
        for (int i = 0; i < 15; i++) clk_edge();
        n_cmp++;
        if (dut_st !== st(15, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL wrap_pc15: got %h want %h", dut_st, st(15, 0, 0, 0, 0));
        end
        clk_edge();
        n_cmp++;
        if (dut_st !== st(0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL wrap_pc0: got %h want %h", dut_st, st(0, 0, 0, 0, 0));
        end
        rom[15] = 8'hFF;
        for (int i = 0; i < 15; i++) clk_edge();
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            n_cmp++;
            if (dut_st !== st(15, 0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL jmp_self %0d: got %h want %h", i, dut_st, st(15, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_stall();
        use_rom = 1'b1;
        load_rom(8'h33, 8'h0E, 8'hE5, 8'hE5);
        do_reset();
        step_en = 1'b1;
        clk_edge();
        use_rom = 1'b0;
        rom_drv = 8'hxx;
        step_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk_edge();
            n_cmp++;
            if (dut_st !== st(1, 3, 0, 0, 0)) begin
                n_err++;
                $display("FAIL stall %0d: got %h want %h", i, dut_st, st(1, 3, 0, 0, 0));
            end
        end
        use_rom = 1'b1;
        rom_drv = 8'h80;
        step_en = 1'b1;
        clk_edge();
        n_cmp++;
        if (dut_st !== st(2, 1, 0, 0, 1)) begin
            n_err++;
            $display("FAIL stall_resume1: got %h want %h", dut_st, st(2, 1, 0, 0, 1));
        end
        clk_edge();
        n_cmp++;
        if (dut_st !== st(3, 1, 0, 0, 0)) begin
            n_err++;
            $display("FAIL stall_resume2: got %h want %h", dut_st, st(3, 1, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        use_rom = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            do_reset();
            for (int k = 0; k < 150; k++) begin
                step_en = ($urandom_range(0, 3) != 0);
                in_port = 4'($urandom);
                clk_edge();
                n_cmp++;
                if (dut_st !== model_st()) begin
                    n_err++;
                    $display("FAIL random r%0d k%0d: got %h want %h", r, k, dut_st, model_st());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_add_jnc();
        test_out();
        test_in_sync();
        test_wrap();
        test_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
